// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with per-lane valid/ack handshake and an accepted-word counter.
// Optional build macro DEMUX4_AUTO_SEL_EN: round-robin lane pointer replaces the sel input.
module demux4_reg #(
    parameter int WIDTH   = 1,
    parameter int COUNT_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   IN,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         sel,
    output logic [WIDTH-1:0]   OUT_A,
    output logic [WIDTH-1:0]   OUT_B,
    output logic [WIDTH-1:0]   OUT_C,
    output logic [WIDTH-1:0]   OUT_D,
    output logic [3:0]         valid,
    input  logic [3:0]         ack,
    output logic [COUNT_W-1:0] count
);

    logic [WIDTH-1:0]   r_data [4];
    logic [3:0]         r_valid;
    logic [COUNT_W-1:0] r_count;
    logic [1:0]         w_tgt;
    logic               w_accept;
    logic [3:0]         w_load;

`ifdef DEMUX4_AUTO_SEL_EN
    logic [1:0] r_rr_ptr;
    logic       w_unused_sel;

    assign w_unused_sel = ^sel;

    // Pointer only moves on accept, so a full unacked lane stalls it rather than being skipped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rr_ptr <= 2'd0;
        end else if (w_accept) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
        end
    end

    assign w_tgt = r_rr_ptr;
`else
    assign w_tgt = sel;
`endif

    // An ack on the target lane frees it in the same cycle, allowing a reload without a bubble.
    assign in_ready = ~r_valid[w_tgt] | ack[w_tgt];
    assign w_accept = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_load[gi] = w_accept && (w_tgt == 2'(gi));

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_data[gi]  <= '0;
                    r_valid[gi] <= 1'b0;
                end else if (w_load[gi]) begin
                    r_data[gi]  <= IN;
                    r_valid[gi] <= 1'b1;
                end else if (ack[gi]) begin
                    r_valid[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    assign OUT_A = r_data[0];
    assign OUT_B = r_data[1];
    assign OUT_C = r_data[2];
    assign OUT_D = r_data[3];
    assign valid = r_valid;
    assign count = r_count;

endmodule

// File: tb/tb_demux4_reg.sv
// Scoreboard bench for demux4_reg: a 8-bit/8-bit-count instance and a 8-bit/2-bit-count instance share stimulus.
module tb_demux4_reg;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] IN;
    logic       in_valid;
    logic [1:0] sel;
    logic [3:0] ack;

    logic       in_ready, in_ready2;
    logic [7:0] OUT_A, OUT_B, OUT_C, OUT_D;
    logic [7:0] OUT_A2, OUT_B2, OUT_C2, OUT_D2;
    logic [3:0] valid, valid2;
    logic [7:0] count;
    logic [1:0] count2;

    always #5 CLK = ~CLK;

    demux4_reg #(.WIDTH(8), .COUNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .IN(IN), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_C(OUT_C), .OUT_D(OUT_D),
        .valid(valid), .ack(ack), .count(count)
    );

    demux4_reg #(.WIDTH(8), .COUNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .IN(IN), .in_valid(in_valid), .in_ready(in_ready2), .sel(sel),
        .OUT_A(OUT_A2), .OUT_B(OUT_B2), .OUT_C(OUT_C2), .OUT_D(OUT_D2),
        .valid(valid2), .ack(ack), .count(count2)
    );

    typedef struct {
        logic [43:0] st1;
        logic [37:0] st2;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Reference model state
    logic [7:0]  m_data [4];
    logic [3:0]  m_valid;
    logic [31:0] m_count;
    logic [1:0]  m_rr;
    logic        m_rdy;

    function automatic logic [43:0] obs1();
        return {OUT_D, OUT_C, OUT_B, OUT_A, valid, count};
    endfunction

    function automatic logic [37:0] obs2();
        return {OUT_D2, OUT_C2, OUT_B2, OUT_A2, valid2, count2};
    endfunction

    // Apply inputs, advance the model by one edge and queue the expected post-edge state.
    task automatic drive(input logic rst, input logic iv, input logic [1:0] s,
                         input logic [7:0] d, input logic [3:0] a);
        logic [1:0] t;
        exp_t       e;
        RST = rst; in_valid = iv; sel = s; IN = d; ack = a;
        #1;
`ifdef DEMUX4_AUTO_SEL_EN
        t = m_rr;
`else
        t = s;
`endif
        m_rdy = !m_valid[t] || a[t];
        if (rst) begin
            for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
            m_valid = 4'b0000;
            m_count = 0;
            m_rr    = 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (iv && m_rdy && (int'(t) == i)) begin
                    m_data[i]  = d;
                    m_valid[i] = 1'b1;
                end else if (a[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (iv && m_rdy) begin
                m_count = m_count + 1;
                m_rr    = m_rr + 2'd1;
            end
        end
        e.st1 = {m_data[3], m_data[2], m_data[1], m_data[0], m_valid, m_count[7:0]};
        e.st2 = {m_data[3], m_data[2], m_data[1], m_data[0], m_valid, m_count[1:0]};
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b1, 1'b1, 2'd0, 8'hFF, 4'hF);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (obs1() !== e.st1) begin n_bad++; $display("FAIL reset_state: got %h want %h", obs1(), e.st1); end
        n_cmp++;
        if ({valid, count, OUT_A, OUT_B, OUT_C, OUT_D} !== 44'h0) begin
            n_bad++; $display("FAIL reset_zero: valid=%b count=%0d outs=%h %h %h %h", valid, count, OUT_A, OUT_B, OUT_C, OUT_D);
        end
        $display("reset: valid=%b count=%0d", valid, count);
    endtask

    task automatic test_steer();
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 1'b1, 2'(s), 8'h01, 4'h0);
            n_cmp++;
            if (in_ready !== m_rdy) begin n_bad++; $display("FAIL steer_ready sel=%0d: got %b want %b", s, in_ready, m_rdy); end
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (obs1() !== e.st1) begin n_bad++; $display("FAIL steer sel=%0d: got %h want %h", s, obs1(), e.st1); end
            $display("steer sel=%0d: valid=%b count=%0d", s, valid, count);
        end
        n_cmp++;
        if ({valid, count, OUT_A, OUT_B, OUT_C, OUT_D} !== {4'hF, 8'd4, 32'h01010101}) begin
            n_bad++; $display("FAIL steer_full: valid=%b count=%0d want 1111/4", valid, count);
        end
        drive(1'b0, 1'b1, 2'd2, 8'h55, 4'h0);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", in_ready); end
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (obs1() !== e.st1 || OUT_C !== 8'h01) begin n_bad++; $display("FAIL full_hold: got %h want %h", obs1(), e.st1); end
        $display("blocked write sel=2: OUT_C=%h count=%0d", OUT_C, count);
    endtask

    task automatic test_ack_reload();
        exp_t e;
        drive(1'b0, 1'b1, 2'd2, 8'h00, 4'b0100);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ack_reload_ready: got %b want 1", in_ready); end
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (obs1() !== e.st1 || OUT_C !== 8'h00 || valid[2] !== 1'b1) begin
            n_bad++; $display("FAIL ack_reload: got %h want %h", obs1(), e.st1);
        end
        $display("ack+reload C: OUT_C=%h valid=%b", OUT_C, valid);
        drive(1'b0, 1'b0, 2'd2, 8'hAA, 4'b0100);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (obs1() !== e.st1 || valid[2] !== 1'b0) begin n_bad++; $display("FAIL ack_only: got %h want %h", obs1(), e.st1); end
        $display("ack C alone: valid=%b OUT_C=%h", valid, OUT_C);
    endtask

    task automatic test_multi_ack();
        exp_t e;
        drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (obs1() !== e.st1 || valid !== 4'b0000) begin n_bad++; $display("FAIL multi_ack: got %h want %h", obs1(), e.st1); end
        $display("multi ack: valid=%b OUT_A=%h", valid, OUT_A);
        drive(1'b0, 1'b0, 2'd0, 8'h00, 4'b1010);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (obs1() !== e.st1) begin n_bad++; $display("FAIL empty_ack: got %h want %h", obs1(), e.st1); end
        $display("ack on empty lanes: valid=%b", valid);
    endtask

    task automatic test_count_wrap();
        exp_t       e;
        logic [1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        drive(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
        tick();
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 2'(i), 8'(8'h10 + i), 4'hF);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (count2 !== seq[i] || obs2() !== e.st2) begin
                n_bad++; $display("FAIL count_wrap step %0d: got %0d want %0d", i, count2, seq[i]);
            end
            $display("wrap accept %0d: count2=%0d count=%0d", i, count2, count);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        drive(1'b0, 1'b1, 2'd3, 8'hC3, 4'h0);
        tick();
        void'(sb.pop_front());
        drive(1'b1, 1'b1, 2'd1, 8'h77, 4'hF);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (obs1() !== e.st1 || obs1() !== 44'h0) begin n_bad++; $display("FAIL mid_reset: got %h want %h", obs1(), e.st1); end
        $display("mid-transfer reset: valid=%b count=%0d", valid, count);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   errs = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
            n_cmp++;
            if (in_ready !== m_rdy || in_ready2 !== m_rdy) begin
                n_bad++; errs++;
                $display("FAIL rand_ready cyc %0d: got %b/%b want %b", i, in_ready, in_ready2, m_rdy);
            end
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (obs1() !== e.st1 || obs2() !== e.st2) begin
                n_bad++; errs++;
                $display("FAIL rand_state cyc %0d: got %h want %h", i, obs1(), e.st1);
            end
        end
        $display("back-to-back: 300 cycles, %0d errors, count=%0d", errs, count);
    endtask

`ifdef DEMUX4_AUTO_SEL_EN
    task automatic test_auto_sel();
        exp_t e;
        drive(1'b1, 1'b0, 2'd3, 8'h00, 4'h0);
        tick();
        void'(sb.pop_front());
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 2'd3, 8'(8'h20 + i), 4'hF);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (obs1() !== e.st1) begin n_bad++; $display("FAIL auto_rr %0d: got %h want %h", i, obs1(), e.st1); end
            $display("auto accept %0d: valid=%b", i, valid);
        end
        drive(1'b1, 1'b0, 2'd3, 8'h00, 4'h0);
        tick();
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 2'd3, 8'(8'h40 + i), (i == 4) ? 4'b0001 : 4'b0000);
            tick();
            void'(sb.pop_front());
        end
        drive(1'b0, 1'b1, 2'd3, 8'h99, 4'h0);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL auto_stall_ready: got %b want 0", in_ready); end
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (obs1() !== e.st1) begin n_bad++; $display("FAIL auto_stall: got %h want %h", obs1(), e.st1); end
        $display("auto stall at B: in_ready=0 valid=%b", valid);
    endtask
`endif

    initial begin
        RST = 1'b1; in_valid = 1'b0; sel = 2'd0; IN = 8'h00; ack = 4'h0;
        m_valid = 4'h0; m_count = 0; m_rr = 2'd0; m_rdy = 1'b0;
        for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
        #2;
        test_reset();
        test_steer();
        test_ack_reload();
        test_multi_ack();
        test_count_wrap();
        test_mid_reset();
        test_back_to_back();
`ifdef DEMUX4_AUTO_SEL_EN
        test_auto_sel();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
